psx_device_port_buffered: RTL and testbench
===========================================

# psx_device_port_buffered

Buffered device-side PSX/PS2 serial engine. It sits behind the select decode and receives a reset that is held high whenever SEL is inactive. It shifts command bytes into a command FIFO, shifts reply bytes out of a reply FIFO that firmware preloads, and generates the ACK pulse with parametrised timing. A per-packet byte counter and sticky error flags are also provided. Pin tristating is done by the enclosing wrapper: this block only drives output values, and 1 means released.

## Interface
Parameters:
- CLOCK_MHZ, 25, system clock frequency in MHz.
- ACK_DELAY_US, 8, delay from byte completion to ACK assertion.
- ACK_WIDTH_US, 3, ACK low width.
- CMD_DEPTH, 8, command FIFO entries; must be a power of two, 2..256.
- REPLY_DEPTH, 8, reply FIFO entries; must be a power of two, 2..256.
- TIMER_W, $clog2(CLOCK_MHZ*(ACK_DELAY_US+ACK_WIDTH_US)+1), ACK timer width.

Ports:
- clk  in  1  system clock.
- PPB_packet_reset  in  1  reset; asynchronous, active-high. High for the whole time SEL is inactive.
- PSX_clk  in  1  asynchronous bus clock; idles high.
- PSX_cmd  in  1  asynchronous command line.
- PSX_dat_o  out  1  reply bit value.
- PSX_ack_o  out  1  ACK value; 0 means asserted.
- cmd_data  out  8  head of the command FIFO, first-word fall-through.
- cmd_valid  out  1  command FIFO is non-empty.
- cmd_rd  in  1  pops the head; ignored when cmd_valid=0.
- reply_data  in  8  reply byte to enqueue.
- reply_wr  in  1  enqueues reply_data; ignored when full.
- reply_full  out  1  reply FIFO is full.
- reply_level  out  $clog2(REPLY_DEPTH)+1  reply FIFO occupancy.
- ack_enable  in  1  request an ACK for the current byte.
- byte_count  out  8  completed bytes in this packet; saturates at 255.
- cmd_overflow  out  1  sticky: a command byte was dropped.
- reply_underrun  out  1  sticky: a reply byte was needed while the FIFO was empty.

## Operation
- PSX_clk and PSX_cmd each pass through 2 synchroniser flops. Both reset to 1. A third flop detects edges of the synchronised clock.
- **RX path.** Bits are sampled on rising edges, LSB first, into a 3-bit bit counter and a shift register.
  - On the 8th rising edge, the assembled byte is pushed into the command FIFO, byte_count increments, and the ACK timer is restarted.
  - If the command FIFO is full and cmd_rd is not asserted in the same cycle, the byte is dropped and cmd_overflow is set. A push and a pop in the same cycle on a full FIFO are both accepted.
- **TX path.** PSX_dat_o changes only on falling edges, LSB first.
  - On the falling edge where the TX bit counter is 0, the head of the reply FIFO is popped and its bit 0 is driven.
  - If the reply FIFO is empty at that edge, 0xFF is transmitted and reply_underrun is set.
  - reply_wr on that same cycle while the FIFO is empty stores the written byte for the next reply byte; it does not rescue the current one.
- **ACK state machine.** States are IDLE, DELAY, PULSE.
  - Byte completion in any state moves to DELAY, clears the timer, clears the armed flag, and sets PSX_ack_o=1.
  - In DELAY, armed is set by ack_enable sampled high on any cycle. When the timer reaches CLOCK_MHZ*ACK_DELAY_US, the block moves to PULSE and PSX_ack_o becomes ~armed.
  - When the timer reaches CLOCK_MHZ*(ACK_DELAY_US+ACK_WIDTH_US), the block moves to IDLE and PSX_ack_o becomes 1.
  - If byte completion and the DELAY expiry fall on the same cycle, completion wins.
- **Reset mid-byte.** Asserting reset aborts any partial byte with no push. Both FIFOs, the flags and the counters clear.

## Timing
- Reset values:
  - PSX_dat_o=1, PSX_ack_o=1.
  - cmd_valid=0, cmd_data=0.
  - reply_full=0, reply_level=0.
  - byte_count=0, cmd_overflow=0, reply_underrun=0.
- RX latency: cmd_valid rises 4 clk after the 8th PSX_clk rising edge (2 sync + 1 edge + 1 FIFO write).
- TX latency: PSX_dat_o updates 3 clk after a PSX_clk falling edge.
- cmd_rd takes effect on the next edge; cmd_data advances on the same cycle that cmd_valid updates.
- reply_level updates 1 clk after reply_wr or a pop. A write and a pop in the same cycle leave the level unchanged.
- ACK falls CLOCK_MHZ*ACK_DELAY_US+1 clk after byte completion and stays low for CLOCK_MHZ*ACK_WIDTH_US clk.

## Configuration
- PSX_DEVICE_PORT_BUFFERED_AUTO_ACK_EN defined: at DELAY expiry, armed is additionally set if reply_level != 0, so a device with queued reply data ACKs automatically.
- Not defined: only ack_enable arms the ACK.

## Test plan
- Preload 0x41,0x5A; host sends 0x01,0x42 with ack_enable=1 → PSX_dat_o carries 0x41 then 0x5A; cmd FIFO holds 0x01,0x42; byte_count=2; two ACK pulses of 75 clk, each starting 201 clk after completion.
- ack_enable=0 and FIFO empty, macro undefined → no ACK; 0xFF transmitted; reply_underrun=1.
- Same as the previous case with the macro defined and 1 byte queued → ACK pulse occurs.
- CMD_DEPTH=8, no cmd_rd, host sends 9 bytes → FIFO holds the first 8; cmd_overflow=1.
- Reset asserted after 5 PSX_clk edges, then a full byte sent → received byte equals the new byte, not a mix with the aborted bits.
- Second byte completes during PULSE → ACK released immediately; new DELAY starts with the armed flag cleared.

Source files
------------

// File: rtl/psx_device_port_buffered.sv
// psx_device_port_buffered: buffered device-side PSX/PS2 serial engine.
// Build option: PSX_DEVICE_PORT_BUFFERED_AUTO_ACK_EN (queued reply data arms ACK).
module psx_device_port_buffered #(
    parameter int CLOCK_MHZ    = 25,
    parameter int ACK_DELAY_US = 8,
    parameter int ACK_WIDTH_US = 3,
    parameter int CMD_DEPTH    = 8,
    parameter int REPLY_DEPTH  = 8,
    parameter int TIMER_W      =
        $clog2(CLOCK_MHZ*(ACK_DELAY_US+ACK_WIDTH_US)+1)
) (
    input  logic                           clk,
    input  logic                           PPB_packet_reset,
    input  logic                           PSX_clk,
    input  logic                           PSX_cmd,
    output logic                           PSX_dat_o,
    output logic                           PSX_ack_o,
    output logic [7:0]                     cmd_data,
    output logic                           cmd_valid,
    input  logic                           cmd_rd,
    input  logic [7:0]                     reply_data,
    input  logic                           reply_wr,
    output logic                           reply_full,
    output logic [$clog2(REPLY_DEPTH):0]   reply_level,
    input  logic                           ack_enable,
    output logic [7:0]                     byte_count,
    output logic                           cmd_overflow,
    output logic                           reply_underrun
);

    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(REPLY_DEPTH);
    localparam int DLY = CLOCK_MHZ * ACK_DELAY_US;
    localparam int TOT = CLOCK_MHZ * (ACK_DELAY_US + ACK_WIDTH_US);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_PULSE
    } ack_state_t;

    // bus synchronisers and edge detection
    logic r_clk_s1, r_clk_s2, r_clk_s3;
    logic r_cmd_s1, r_cmd_s2;
    logic w_rise, w_fall;

    // receive shifter
    logic [2:0] r_rx_cnt;
    logic [7:0] r_rx_sh;
    logic [7:0] r_rx_byte;
    logic       r_rx_done;
    logic [7:0] w_rx_next;

    // command FIFO
    logic [7:0] r_cmd_mem [CMD_DEPTH];
    logic [CAW:0] r_cmd_wp, r_cmd_rp;
    logic [CAW:0] w_cmd_cnt;
    logic w_cmd_empty, w_cmd_full;
    logic w_cmd_pop, w_cmd_push;

    // reply FIFO
    logic [7:0] r_rep_mem [REPLY_DEPTH];
    logic [RAW:0] r_rep_wp, r_rep_rp;
    logic [RAW:0] w_rep_cnt;
    logic w_rep_empty, w_rep_full;
    logic w_rep_pop, w_rep_push;

    // transmit shifter
    logic [2:0] r_tx_cnt;
    logic [7:0] r_tx_sh;
    logic       r_dat;
    logic       w_tx_load;
    logic [7:0] w_tx_byte;

    // status
    logic [7:0] r_byte_cnt;
    logic       r_ovf, r_und;

    // ACK machine
    ack_state_t       r_state, w_state_nx;
    logic [TIMER_W-1:0] r_timer, w_timer_nx;
    logic             r_armed, w_armed_nx;
    logic             r_ack, w_ack_nx;
    logic             w_arm_now, w_arm_exp;

    // two-flop synchronisers plus one edge-history flop; idle value is 1
    always_ff @(posedge clk or posedge PPB_packet_reset) begin
        if (PPB_packet_reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_clk_s3 <= 1'b1;
            r_cmd_s1 <= 1'b1;
            r_cmd_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= PSX_clk;
            r_clk_s2 <= r_clk_s1;
            r_clk_s3 <= r_clk_s2;
            r_cmd_s1 <= PSX_cmd;
            r_cmd_s2 <= r_cmd_s1;
        end
    end

    assign w_rise = r_clk_s2 & ~r_clk_s3;
    assign w_fall = ~r_clk_s2 & r_clk_s3;

    assign w_rx_next = {r_cmd_s2, r_rx_sh[7:1]};

    // assemble LSB-first bytes on rising edges; flag the 8th bit
    always_ff @(posedge clk or posedge PPB_packet_reset) begin
        if (PPB_packet_reset) begin
            r_rx_cnt  <= 3'd0;
            r_rx_sh   <= 8'h00;
            r_rx_byte <= 8'h00;
            r_rx_done <= 1'b0;
        end else begin
            r_rx_done <= 1'b0;
            if (w_rise) begin
                r_rx_sh  <= w_rx_next;
                r_rx_cnt <= r_rx_cnt + 3'd1;
                if (r_rx_cnt == 3'd7) begin
                    r_rx_done <= 1'b1;
                    r_rx_byte <= w_rx_next;
                end
            end
        end
    end

    assign w_cmd_cnt   = r_cmd_wp - r_cmd_rp;
    assign w_cmd_empty = (r_cmd_wp == r_cmd_rp);
    assign w_cmd_full  = (w_cmd_cnt == (CAW+1)'(CMD_DEPTH));
    assign w_cmd_pop   = cmd_rd & ~w_cmd_empty;
    // a pop in the same cycle frees the slot for a push into a full FIFO
    assign w_cmd_push  = r_rx_done & (~w_cmd_full | w_cmd_pop);

    // command FIFO storage
    always_ff @(posedge clk) begin
        if (w_cmd_push)
            r_cmd_mem[r_cmd_wp[CAW-1:0]] <= r_rx_byte;
    end

    // command FIFO pointers and overflow flag
    always_ff @(posedge clk or posedge PPB_packet_reset) begin
        if (PPB_packet_reset) begin
            r_cmd_wp <= '0;
            r_cmd_rp <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_cmd_push)
                r_cmd_wp <= r_cmd_wp + 1'b1;
            if (w_cmd_pop)
                r_cmd_rp <= r_cmd_rp + 1'b1;
            if (r_rx_done & ~w_cmd_push)
                r_ovf <= 1'b1;
        end
    end

    assign cmd_valid = ~w_cmd_empty;
    assign cmd_data  = w_cmd_empty ? 8'h00
                                   : r_cmd_mem[r_cmd_rp[CAW-1:0]];

    // completed bytes in this packet, saturating
    always_ff @(posedge clk or posedge PPB_packet_reset) begin
        if (PPB_packet_reset)
            r_byte_cnt <= 8'd0;
        else if (r_rx_done && r_byte_cnt != 8'hFF)
            r_byte_cnt <= r_byte_cnt + 8'd1;
    end

    assign w_rep_cnt   = r_rep_wp - r_rep_rp;
    assign w_rep_empty = (r_rep_wp == r_rep_rp);
    assign w_rep_full  = (w_rep_cnt == (RAW+1)'(REPLY_DEPTH));
    assign w_tx_load   = w_fall & (r_tx_cnt == 3'd0);
    assign w_rep_pop   = w_tx_load & ~w_rep_empty;
    assign w_rep_push  = reply_wr & ~w_rep_full;

    // reply FIFO storage
    always_ff @(posedge clk) begin
        if (w_rep_push)
            r_rep_mem[r_rep_wp[RAW-1:0]] <= reply_data;
    end

    // reply FIFO pointers
    always_ff @(posedge clk or posedge PPB_packet_reset) begin
        if (PPB_packet_reset) begin
            r_rep_wp <= '0;
            r_rep_rp <= '0;
        end else begin
            if (w_rep_push)
                r_rep_wp <= r_rep_wp + 1'b1;
            if (w_rep_pop)
                r_rep_rp <= r_rep_rp + 1'b1;
        end
    end

    assign reply_full  = w_rep_full;
    assign reply_level = w_rep_cnt;

    // an empty FIFO at byte start sends all ones
    assign w_tx_byte = w_rep_empty ? 8'hFF
                                   : r_rep_mem[r_rep_rp[RAW-1:0]];

    // drive reply bits LSB first on falling edges
    always_ff @(posedge clk or posedge PPB_packet_reset) begin
        if (PPB_packet_reset) begin
            r_tx_cnt <= 3'd0;
            r_tx_sh  <= 8'hFF;
            r_dat    <= 1'b1;
            r_und    <= 1'b0;
        end else if (w_fall) begin
            r_tx_cnt <= r_tx_cnt + 3'd1;
            if (r_tx_cnt == 3'd0) begin
                r_dat   <= w_tx_byte[0];
                r_tx_sh <= {1'b1, w_tx_byte[7:1]};
                if (w_rep_empty)
                    r_und <= 1'b1;
            end else begin
                r_dat   <= r_tx_sh[0];
                r_tx_sh <= {1'b1, r_tx_sh[7:1]};
            end
        end
    end

    assign w_arm_now = r_armed | ack_enable;
`ifdef PSX_DEVICE_PORT_BUFFERED_AUTO_ACK_EN
    assign w_arm_exp = w_arm_now | (w_rep_cnt != '0);
`else
    assign w_arm_exp = w_arm_now;
`endif

    // ACK state register
    always_ff @(posedge clk or posedge PPB_packet_reset) begin
        if (PPB_packet_reset) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_armed <= 1'b0;
            r_ack   <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_timer <= w_timer_nx;
            r_armed <= w_armed_nx;
            r_ack   <= w_ack_nx;
        end
    end

    // ACK next state: byte completion overrides every other transition
    always_comb begin
        w_state_nx = r_state;
        w_timer_nx = r_timer;
        w_armed_nx = r_armed;
        w_ack_nx   = r_ack;
        if (r_rx_done) begin
            w_state_nx = S_DELAY;
            w_timer_nx = '0;
            w_armed_nx = 1'b0;
            w_ack_nx   = 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_ack_nx = 1'b1;
                end
                S_DELAY: begin
                    w_timer_nx = r_timer + 1'b1;
                    w_armed_nx = w_arm_now;
                    if (r_timer == TIMER_W'(DLY)) begin
                        w_state_nx = S_PULSE;
                        w_armed_nx = w_arm_exp;
                        w_ack_nx   = ~w_arm_exp;
                    end
                end
                S_PULSE: begin
                    w_timer_nx = r_timer + 1'b1;
                    if (r_timer == TIMER_W'(TOT)) begin
                        w_state_nx = S_IDLE;
                        w_ack_nx   = 1'b1;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_ack_nx   = 1'b1;
                end
            endcase
        end
    end

    assign PSX_dat_o      = r_dat;
    assign PSX_ack_o      = r_ack;
    assign byte_count     = r_byte_cnt;
    assign cmd_overflow   = r_ovf;
    assign reply_underrun = r_und;

endmodule

// File: tb/tb_psx_device_port_buffered.sv
// tb_psx_device_port_buffered: directed bench with a queue-based model
// of the device port, checked every clock, plus literal expectations.
`timescale 1ns/1ps
module tb_psx_device_port_buffered;

    localparam int CD   = 8;
    localparam int RD   = 8;
    localparam int HALF = 8;
    localparam int DLY  = 25 * 8;
    localparam int WID  = 25 * 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       PSX_clk = 1'b1;
    logic       PSX_cmd = 1'b1;
    logic       cmd_rd = 1'b0;
    logic       reply_wr = 1'b0;
    logic [7:0] reply_data = 8'h00;
    logic       ack_enable = 1'b0;

    logic       PSX_dat_o, PSX_ack_o;
    logic [7:0] cmd_data, byte_count;
    logic       cmd_valid, reply_full;
    logic [3:0] reply_level;
    logic       cmd_overflow, reply_underrun;

    psx_device_port_buffered #(
        .CLOCK_MHZ(25), .ACK_DELAY_US(8), .ACK_WIDTH_US(3),
        .CMD_DEPTH(CD), .REPLY_DEPTH(RD)
    ) dut (
        .clk(clk), .PPB_packet_reset(rst),
        .PSX_clk(PSX_clk), .PSX_cmd(PSX_cmd),
        .PSX_dat_o(PSX_dat_o), .PSX_ack_o(PSX_ack_o),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_rd(cmd_rd),
        .reply_data(reply_data), .reply_wr(reply_wr),
        .reply_full(reply_full), .reply_level(reply_level),
        .ack_enable(ack_enable), .byte_count(byte_count),
        .cmd_overflow(cmd_overflow), .reply_underrun(reply_underrun)
    );

    always #20 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state
    int         cyc = 0;
    bit         prev_clk;
    logic [7:0] m_cmdq[$];
    logic [7:0] m_repq[$];
    int         rx_due[$];
    bit         rx_bit[$];
    int         tx_due[$];
    logic [7:0] m_rx_sh;
    int         m_rx_n;
    logic [7:0] m_tx_byte;
    int         m_tx_i;
    logic       m_dat, m_ack, m_ovf, m_und;
    int         m_bc;
    bit         m_act, m_armed;
    int         m_comp;

    // observations for literal timing checks
    int         ack_fall[$];
    int         ack_rise[$];
    int         bc_chg[$];
    logic       prev_ack;
    logic [7:0] prev_bc;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_cmdq.delete(); m_repq.delete();
        rx_due.delete(); rx_bit.delete(); tx_due.delete();
        m_rx_sh = 8'h00; m_rx_n = 0;
        m_tx_byte = 8'hFF; m_tx_i = 0;
        m_dat = 1'b1; m_ack = 1'b1; m_ovf = 1'b0; m_und = 1'b0;
        m_bc = 0; m_act = 1'b0; m_armed = 1'b0; m_comp = 0;
        prev_clk = 1'b1;
    endtask

    // one clock of the behavioural model, from the pins seen at this edge
    task automatic model_step();
        bit         comp, rd_pop, rep_full_pre, acc, b;
        int         rep_lvl_pre, k, d;
        logic [7:0] cbyte;
        cyc++;
        if (rst) begin
            model_clear();
            return;
        end
        // bus edges take effect after the synchroniser latency
        if (PSX_clk && !prev_clk) begin
            rx_due.push_back(cyc + 3);
            rx_bit.push_back(PSX_cmd);
        end
        if (!PSX_clk && prev_clk)
            tx_due.push_back(cyc + 2);
        prev_clk = PSX_clk;

        comp  = 1'b0;
        cbyte = 8'h00;
        if (rx_due.size() > 0 && rx_due[0] == cyc) begin
            d = rx_due.pop_front();
            b = rx_bit.pop_front();
            m_rx_sh = {b, m_rx_sh[7:1]};
            m_rx_n++;
            if (m_rx_n == 8) begin
                comp = 1'b1; cbyte = m_rx_sh; m_rx_n = 0;
            end
        end

        rep_lvl_pre  = m_repq.size();
        rep_full_pre = (rep_lvl_pre == RD);
        rd_pop       = cmd_rd && m_cmdq.size() > 0;

        // ACK: low from DLY+1 to DLY+WID+1 cycles after completion if armed
        if (comp) begin
            m_ack = 1'b1; m_act = 1'b1; m_comp = cyc; m_armed = 1'b0;
        end else if (m_act) begin
            k = cyc - m_comp;
            if (k <= DLY + 1 && ack_enable)
                m_armed = 1'b1;
            if (k == DLY + 1) begin
`ifdef PSX_DEVICE_PORT_BUFFERED_AUTO_ACK_EN
                if (rep_lvl_pre != 0)
                    m_armed = 1'b1;
`endif
                m_ack = !m_armed;
            end
            if (k == DLY + 1 + WID) begin
                m_ack = 1'b1; m_act = 1'b0;
            end
        end

        acc = (m_cmdq.size() < CD) || rd_pop;
        if (rd_pop)
            d = int'(m_cmdq.pop_front());
        if (comp) begin
            if (acc) m_cmdq.push_back(cbyte);
            else     m_ovf = 1'b1;
            if (m_bc < 255) m_bc++;
        end

        if (tx_due.size() > 0 && tx_due[0] == cyc) begin
            d = tx_due.pop_front();
            if (m_tx_i == 0) begin
                if (rep_lvl_pre == 0) begin
                    m_tx_byte = 8'hFF; m_und = 1'b1;
                end else begin
                    m_tx_byte = m_repq.pop_front();
                end
            end
            m_dat  = m_tx_byte[m_tx_i];
            m_tx_i = (m_tx_i + 1) % 8;
        end
        if (reply_wr && !rep_full_pre)
            m_repq.push_back(reply_data);
    endtask

    task automatic compare();
        chk("dat", PSX_dat_o, m_dat);
        chk("ack", PSX_ack_o, m_ack);
        chk("cmd_valid", cmd_valid, m_cmdq.size() != 0);
        chk("cmd_data", cmd_data, m_cmdq.size() != 0 ? m_cmdq[0] : 8'h00);
        chk("reply_level", reply_level, m_repq.size());
        chk("reply_full", reply_full, m_repq.size() == RD);
        chk("byte_count", byte_count, m_bc);
        chk("cmd_overflow", cmd_overflow, m_ovf);
        chk("reply_underrun", reply_underrun, m_und);
    endtask

    // model step, compare and edge observation on every clock
    initial begin
        prev_ack = 1'b1;
        prev_bc  = 8'h00;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            compare();
            if (!rst) begin
                if (PSX_ack_o === 1'b0 && prev_ack === 1'b1)
                    ack_fall.push_back(cyc);
                if (PSX_ack_o === 1'b1 && prev_ack === 1'b0)
                    ack_rise.push_back(cyc);
                if (byte_count !== prev_bc)
                    bc_chg.push_back(cyc);
            end
            prev_ack = PSX_ack_o;
            prev_bc  = byte_count;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; PSX_clk = 1'b1; PSX_cmd = 1'b1;
        cmd_rd = 1'b0; reply_wr = 1'b0; ack_enable = 1'b0;
        tick(4);
        ack_fall.delete(); ack_rise.delete(); bc_chg.delete();
        rst = 1'b0;
        tick(2);
    endtask

    // host side: drive n bits LSB first, capture reply on rising edges
    task automatic send_bits(input logic [7:0] b, input int n,
                             output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            PSX_clk = 1'b0; PSX_cmd = b[i];
            tick(HALF);
            PSX_clk = 1'b1; rx[i] = PSX_dat_o;
            tick(HALF);
        end
        PSX_cmd = 1'b1;
    endtask

    task automatic preload(input logic [7:0] b);
        reply_wr = 1'b1; reply_data = b;
        tick(1);
        reply_wr = 1'b0;
    endtask

    task automatic pop();
        cmd_rd = 1'b1;
        tick(1);
        cmd_rd = 1'b0;
    endtask

    logic [7:0] r0, r1;
    int         exp_auto;

    initial begin
        model_clear();
        // reset values while reset is held
        tick(3);
        chk("rst_dat", PSX_dat_o, 1'b1);
        chk("rst_ack", PSX_ack_o, 1'b1);
        chk("rst_valid", cmd_valid, 1'b0);
        chk("rst_data", cmd_data, 8'h00);
        chk("rst_level", reply_level, 4'd0);
        do_reset();

        // two-byte exchange with ACK requested
        preload(8'h41);
        preload(8'h5A);
        tick(1);
        chk("t1_level", reply_level, 4'd2);
        ack_enable = 1'b1;
        send_bits(8'h01, 8, r0);
        tick(300);
        send_bits(8'h42, 8, r1);
        tick(300);
        ack_enable = 1'b0;
        chk("t1_tx0", r0, 8'h41);
        chk("t1_tx1", r1, 8'h5A);
        chk("t1_bc", byte_count, 8'd2);
        chk("t1_head", cmd_data, 8'h01);
        chk("t1_nfall", ack_fall.size(), 2);
        if (ack_fall.size() == 2 && ack_rise.size() == 2 &&
            bc_chg.size() == 2) begin
            for (int i = 0; i < 2; i++) begin
                chk("t1_ack_delay", ack_fall[i] - bc_chg[i], 201);
                chk("t1_ack_width", ack_rise[i] - ack_fall[i], 75);
            end
        end
        pop();
        chk("t1_head2", cmd_data, 8'h42);
        pop();
        chk("t1_empty", cmd_valid, 1'b0);

        // no ACK request and empty reply FIFO
        do_reset();
        send_bits(8'h33, 8, r0);
        tick(300);
        chk("t2_tx", r0, 8'hFF);
        chk("t2_und", reply_underrun, 1'b1);
        chk("t2_nfall", ack_fall.size(), 0);
        chk("t2_head", cmd_data, 8'h33);

        // one byte still queued at DELAY expiry
        do_reset();
        preload(8'h77);
        preload(8'h88);
        send_bits(8'hC3, 8, r0);
        tick(300);
`ifdef PSX_DEVICE_PORT_BUFFERED_AUTO_ACK_EN
        exp_auto = 1;
`else
        exp_auto = 0;
`endif
        chk("t3_tx", r0, 8'h77);
        chk("t3_nfall", ack_fall.size(), exp_auto);

        // nine bytes into an eight-entry FIFO
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send_bits(8'h10 + 8'(i), 8, r0);
            tick(4);
        end
        tick(10);
        chk("t4_ovf", cmd_overflow, 1'b1);
        chk("t4_bc", byte_count, 8'd9);
        for (int i = 0; i < 8; i++) begin
            chk("t4_data", cmd_data, 8'h10 + 8'(i));
            pop();
        end
        chk("t4_empty", cmd_valid, 1'b0);

        // reset aborts a partial byte
        do_reset();
        send_bits(8'hAA, 5, r0);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
        send_bits(8'h5C, 8, r0);
        tick(10);
        chk("t5_data", cmd_data, 8'h5C);
        chk("t5_bc", byte_count, 8'd1);
        pop();
        chk("t5_empty", cmd_valid, 1'b0);

        // second byte completes during the pulse
        do_reset();
        ack_enable = 1'b1;
        send_bits(8'hA1, 8, r0);
        tick(50);
        ack_enable = 1'b0;
        tick(45);
        send_bits(8'hA2, 8, r0);
        tick(300);
        chk("t6_nfall", ack_fall.size(), 1);
        chk("t6_nrise", ack_rise.size(), 1);
        chk("t6_nbc", bc_chg.size(), 2);
        if (ack_fall.size() == 1 && ack_rise.size() == 1 &&
            bc_chg.size() == 2) begin
            chk("t6_delay", ack_fall[0] - bc_chg[0], 201);
            chk("t6_release", ack_rise[0], bc_chg[1]);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
